core_sram_responder: RTL and testbench
======================================

CORE_SRAM_RESPONDER -- requirements
Module: core_sram_responder

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WIDTH, default 9, word-address width of the attached SRAM (512 x 32-bit words).
REQ-002 SHALL have clk  input  1  sole clock; one clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset; reset is asynchronous and active-low.
REQ-004 SHALL have core_address  input  32  core byte address; bits [SRAM_ADDR_WIDTH+1:2] select the word, other bits ignored.
REQ-005 SHALL have core_byteSelect  input  4  core byte lane mask.
REQ-006 SHALL have core_writeEnable  input  1  core write request, held until core_ready.
REQ-007 SHALL have core_readEnable  input  1  core read request, held until core_ready.
REQ-008 SHALL have core_dataWrite  input  32  core write data.
REQ-009 SHALL have core_dataRead  output  32  read data, valid only while core_ready is high.
REQ-010 SHALL have core_ready  output  1  one-cycle completion strobe for the core request.
REQ-011 SHALL have wb_cyc_i  input  1  management Wishbone cycle.
REQ-012 SHALL have wb_stb_i  input  1  management Wishbone strobe.
REQ-013 SHALL have wb_we_i  input  1  management write.
REQ-014 SHALL have wb_sel_i  input  4  management byte select.
REQ-015 SHALL have wb_adr_i  input  32  management byte address, decoded like core_address.
REQ-016 SHALL have wb_dat_i  input  32  management write data.
REQ-017 SHALL have wb_ack_o  output  1  one-cycle management acknowledge.
REQ-018 SHALL have wb_dat_o  output  32  management read data, valid only with wb_ack_o.
REQ-019 SHALL have sram_csb0  output  1  SRAM chip select, active-low.
REQ-020 SHALL have sram_web0  output  1  SRAM write enable, active-low.
REQ-021 SHALL have sram_wmask0, sram_addr0, sram_din0  outputs  4 / SRAM_ADDR_WIDTH / 32  SRAM mask, word address, write data.
REQ-022 SHALL have sram_dout0  input  32  SRAM read data, valid the cycle after the access.

Function
REQ-023 FSM states IDLE, ACCESS, RESPOND; RESPOND exists only with the Configuration macro defined.
REQ-024 IDLE: a request is core (readEnable|writeEnable) or management (wb_cyc_i&wb_stb_i); a granted request drives the SRAM combinationally in that cycle (csb0=0, web0=!write, wmask0=byte select, addr0=word address, din0=write data), then the FSM moves to ACCESS.
REQ-025 Arbitration: a lone requester wins; simultaneous requests alternate via a last-grant flag, management first after reset; the loser stays pending without loss.
REQ-026 ACCESS (no macro): pulse ready/ack of the granted port for exactly one cycle, return to IDLE; read data = sram_dout0 with lanes not selected forced to 0x00.
REQ-027 Write latency and read latency SHALL both be 1 cycle (request accepted cycle N, strobe cycle N+1).
REQ-028 Non-granted port's strobe SHALL stay 0 and its data output SHALL be 0.
REQ-029 SRAM SHALL be deselected (csb0=1, web0=1, other SRAM outputs 0) in every cycle except the granting IDLE cycle.
REQ-030 A request with both core_readEnable and core_writeEnable SHALL be treated as a write.
REQ-031 Request deasserted mid-transaction SHALL still complete; the strobe is issued and ignored.
REQ-032 IDLE in the cycle after a strobe SHALL re-sample requests, so back-to-back core requests issue every 2 cycles.
REQ-033 Byte select 4'b0000 with an enable SHALL complete normally with wmask0=0 and read data 0.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, last-grant flag, all strobes 0, all data outputs 0, csb0=1, web0=1; an in-flight transaction is dropped without a strobe.
REQ-035 SRAM contents SHALL not be touched by reset.

Configuration
REQ-036 Macro SRAM_OUTPUT_REGISTER_EN defined: ACCESS registers masked sram_dout0, RESPOND drives the strobe, latency 2 cycles.
REQ-037 Macro undefined: no RESPOND state, no data register, latency 1 cycle per REQ-026.

Verification
REQ-038 Core write 0x12345678 to 0x010, sel 1111, then read 0x010 -> core_ready at N+1 each, read data 0x12345678.
REQ-039 Core write 0xAB, sel 0010, to 0x010, then read sel 1111 -> 0x1234AB78.
REQ-040 Core read and wb read asserted same cycle from reset -> wb_ack_o first, core_ready 2 cycles later (no macro).
REQ-041 rst_n low in ACCESS -> no strobe, csb0=1 immediately, next request after release completes normally.
REQ-042 Macro defined, core read 0x010 -> core_ready at N+2, read data identical to no-macro run.

Source files
------------

// File: rtl/core_sram_responder.sv
// Single-port SRAM responder arbitrating a core port and a Wishbone management port.
// Define SRAM_OUTPUT_REGISTER_EN to register read data and add a RESPOND cycle (latency 2).
module core_sram_responder #(
  parameter int SRAM_ADDR_WIDTH = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                core_address,
  input  logic [3:0]                 core_byteSelect,
  input  logic                       core_writeEnable,
  input  logic                       core_readEnable,
  input  logic [31:0]                core_dataWrite,
  output logic [31:0]                core_dataRead,
  output logic                       core_ready,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [3:0]                 wb_sel_i,
  input  logic [31:0]                wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  output logic                       wb_ack_o,
  output logic [31:0]                wb_dat_o,
  output logic                       sram_csb0,
  output logic                       sram_web0,
  output logic [3:0]                 sram_wmask0,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr0,
  output logic [31:0]                sram_din0,
  input  logic [31:0]                sram_dout0
);

`ifdef SRAM_OUTPUT_REGISTER_EN
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;
`else
  typedef enum logic [0:0] {IDLE, ACCESS} state_e;
`endif

  state_e      state_q;
  logic        owner_wb_q;
  logic        last_wb_q;
  logic [3:0]  sel_q;
  logic        core_req;
  logic        wb_req;
  logic        grant_wb;
  logic        grant_any;
  logic        strobe;
  logic [31:0] resp_data;
  logic        unused_addr_bits;

  function automatic logic [31:0] expand_sel(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

  assign core_req  = core_readEnable | core_writeEnable;
  assign wb_req    = wb_cyc_i & wb_stb_i;
  // On contention the port that did not win last time goes first
  assign grant_wb  = wb_req & (~core_req | ~last_wb_q);
  // Gated by rst_n so a request held through reset cannot select the SRAM
  assign grant_any = rst_n & (state_q == IDLE) & (core_req | wb_req);

  assign unused_addr_bits = ^{core_address[31:SRAM_ADDR_WIDTH+2], core_address[1:0],
                              wb_adr_i[31:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0]};

  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (grant_any) begin
      sram_csb0 = 1'b0;
      if (grant_wb) begin
        sram_web0   = ~wb_we_i;
        sram_wmask0 = wb_sel_i;
        sram_addr0  = wb_adr_i[SRAM_ADDR_WIDTH+1:2];
        sram_din0   = wb_dat_i;
      end else begin
        sram_web0   = ~core_writeEnable;
        sram_wmask0 = core_byteSelect;
        sram_addr0  = core_address[SRAM_ADDR_WIDTH+1:2];
        sram_din0   = core_dataWrite;
      end
    end
  end

`ifdef SRAM_OUTPUT_REGISTER_EN
  logic [31:0] data_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_wb_q <= 1'b0;
      last_wb_q  <= 1'b0;
      sel_q      <= '0;
`ifdef SRAM_OUTPUT_REGISTER_EN
      data_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            state_q    <= ACCESS;
            owner_wb_q <= grant_wb;
            last_wb_q  <= grant_wb;
            sel_q      <= grant_wb ? wb_sel_i : core_byteSelect;
          end
        end
        ACCESS: begin
`ifdef SRAM_OUTPUT_REGISTER_EN
          data_q  <= sram_dout0 & expand_sel(sel_q);
          state_q <= RESPOND;
`else
          state_q <= IDLE;
`endif
        end
`ifdef SRAM_OUTPUT_REGISTER_EN
        RESPOND: state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SRAM_OUTPUT_REGISTER_EN
  assign strobe    = (state_q == RESPOND);
  assign resp_data = data_q;
`else
  assign strobe    = (state_q == ACCESS);
  assign resp_data = sram_dout0 & expand_sel(sel_q);
`endif

  assign core_ready    = strobe & ~owner_wb_q;
  assign wb_ack_o      = strobe & owner_wb_q;
  assign core_dataRead = core_ready ? resp_data : '0;
  assign wb_dat_o      = wb_ack_o ? resp_data : '0;

endmodule

// File: tb/tb_core_sram_responder.sv
// Randomized bench for core_sram_responder against a transaction-level memory/arbiter model.
// Honors SRAM_OUTPUT_REGISTER_EN to select the expected latency.
module tb_core_sram_responder;

`ifdef SRAM_OUTPUT_REGISTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] core_address, core_dataWrite, core_dataRead;
  logic [3:0]  core_byteSelect;
  logic        core_writeEnable, core_readEnable, core_ready;
  logic        wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;

  always #5 clk = ~clk;

  core_sram_responder #(.SRAM_ADDR_WIDTH(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_address(core_address), .core_byteSelect(core_byteSelect),
    .core_writeEnable(core_writeEnable), .core_readEnable(core_readEnable),
    .core_dataWrite(core_dataWrite), .core_dataRead(core_dataRead), .core_ready(core_ready),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  // Attached SRAM device: one-cycle read latency, byte-masked writes
  logic [31:0] mem [0:511];
  bit          mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else if (!sram_csb0) begin
      if (!sram_web0)
        mem[sram_addr0] <= (mem[sram_addr0] & ~lanes(sram_wmask0)) | (sram_din0 & lanes(sram_wmask0));
      else
        sram_dout0 <= mem[sram_addr0];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Stimulus: each port holds its request until the model says it completed
  bit          c_pend, c_we, c_re, w_pend, w_we;
  logic [31:0] c_adr, c_wd, w_adr, w_wd;
  logic [3:0]  c_sel, w_sel;

  // Reference model
  logic [31:0] ref_mem [0:511];
  int          cyc = 0;
  int          busy_until = 0;
  int          strobe_cyc = -1;
  bit          owner_wb, last_wb, exp_is_read;
  logic [31:0] exp_rd;
  int          core_obs, wb_obs;
  logic [31:0] last_core_rd, last_wb_rd;

  task automatic drive();
    core_writeEnable = c_pend & c_we;
    core_readEnable  = c_pend & c_re;
    core_address     = c_adr;
    core_byteSelect  = c_sel;
    core_dataWrite   = c_wd;
    wb_cyc_i         = w_pend;
    wb_stb_i         = w_pend;
    wb_we_i          = w_we;
    wb_sel_i         = w_sel;
    wb_adr_i         = w_adr;
    wb_dat_i         = w_wd;
  endtask

  task automatic model_check();
    bit          gw, we;
    logic [3:0]  s;
    logic [31:0] a, d, m;
    int          word;
    if (cyc >= busy_until && (c_pend || w_pend)) begin
      gw = w_pend && (!c_pend || !last_wb);
      last_wb = gw;
      owner_wb = gw;
      strobe_cyc = cyc + LAT;
      busy_until = strobe_cyc + 1;
      we = gw ? w_we : c_we;
      s  = gw ? w_sel : c_sel;
      a  = gw ? w_adr : c_adr;
      d  = gw ? w_wd : c_wd;
      word = int'(a[10:2]);
      m = lanes(s);
      check_eq("csb_grant", 32'(sram_csb0), 32'(0));
      check_eq("web_grant", 32'(sram_web0), 32'(!we));
      check_eq("wmask", 32'(sram_wmask0), 32'(s));
      check_eq("addr", 32'(sram_addr0), 32'(word));
      check_eq("din", sram_din0, d);
      exp_is_read = !we;
      exp_rd = ref_mem[word] & m;
      if (we) ref_mem[word] = (ref_mem[word] & ~m) | (d & m);
    end else begin
      check_eq("csb_idle", 32'(sram_csb0), 32'(1));
      check_eq("web_idle", 32'(sram_web0), 32'(1));
      check_eq("sram_out_idle", {sram_wmask0, 19'(sram_addr0), 9'd0} | sram_din0, 32'h0);
    end
    if (cyc == strobe_cyc) begin
      check_eq("core_ready", 32'(core_ready), 32'(!owner_wb));
      check_eq("wb_ack", 32'(wb_ack_o), 32'(owner_wb));
      if (owner_wb) begin
        check_eq("core_data_nongrant", core_dataRead, 32'h0);
        if (exp_is_read) check_eq("wb_rdata", wb_dat_o, exp_rd);
        w_pend = 1'b0;
        wb_obs = cyc;
        last_wb_rd = wb_dat_o;
      end else begin
        check_eq("wb_data_nongrant", wb_dat_o, 32'h0);
        if (exp_is_read) check_eq("core_rdata", core_dataRead, exp_rd);
        c_pend = 1'b0;
        core_obs = cyc;
        last_core_rd = core_dataRead;
      end
    end else begin
      check_eq("strobes_quiet", {30'd0, core_ready, wb_ack_o}, 32'h0);
      check_eq("data_quiet", core_dataRead | wb_dat_o, 32'h0);
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_csb", 32'(sram_csb0), 32'(1));
    check_eq("rst_web", 32'(sram_web0), 32'(1));
    check_eq("rst_strobes", {30'd0, core_ready, wb_ack_o}, 32'h0);
    check_eq("rst_data", core_dataRead | wb_dat_o, 32'h0);
    @(negedge clk);
    c_pend = 1'b0;
    w_pend = 1'b0;
    drive();
    @(negedge clk);
    check_eq("rst_hold_csb", 32'(sram_csb0), 32'(1));
    rst_n = 1'b1;
    busy_until = cyc;
    strobe_cyc = -1;
    last_wb = 1'b0;
  endtask

  task automatic set_core(input bit we, input bit re, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] wd);
    c_pend = 1'b1; c_we = we; c_re = re; c_adr = adr; c_sel = sel; c_wd = wd;
  endtask

  task automatic run_core(input string tag);
    int t0;
    t0 = cyc;
    for (int i = 0; i < 10 && c_pend; i++) step();
    check_eq({tag, "_done"}, 32'(c_pend), 32'(0));
    check_eq({tag, "_lat"}, 32'(core_obs - t0), 32'(LAT));
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] word;
    word = ($urandom_range(0, 7) == 0) ? 32'd511 : 32'($urandom_range(0, 15));
    return ($urandom() & 32'hFFFF_F803) | (word << 2);
  endfunction

  initial begin
    int t0, r;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    c_pend = 0; c_we = 0; c_re = 0; c_adr = '0; c_sel = '0; c_wd = '0;
    w_pend = 0; w_we = 0; w_adr = '0; w_sel = '0; w_wd = '0;
    core_obs = 0; wb_obs = 0; last_core_rd = '0; last_wb_rd = '0;
    owner_wb = 0; last_wb = 0; exp_is_read = 0; exp_rd = '0;
    drive();
    #2;
    do_reset();
    mem_clr = 1'b0;

    set_core(1, 0, 32'h010, 4'hF, 32'h1234_5678); run_core("wr_full");
    set_core(0, 1, 32'h010, 4'hF, 32'h0);         run_core("rd_full");
    check_eq("rd_full_data", last_core_rd, 32'h1234_5678);
    set_core(1, 0, 32'h010, 4'b0010, 32'h0000_AB00); run_core("wr_lane1");
    set_core(0, 1, 32'h010, 4'hF, 32'h0);            run_core("rd_merged");
    check_eq("rd_merged_data", last_core_rd, 32'h1234_AB78);
    set_core(0, 1, 32'hABCD_E812, 4'hF, 32'h0);      run_core("rd_alias");
    check_eq("rd_alias_data", last_core_rd, 32'h1234_AB78);
    set_core(0, 1, 32'h010, 4'b0000, 32'h0);         run_core("rd_nosel");
    check_eq("rd_nosel_data", last_core_rd, 32'h0);
    set_core(1, 1, 32'h018, 4'hF, 32'h5A5A_0F0F);    run_core("rdwr_both");
    set_core(0, 1, 32'h018, 4'hF, 32'h0);            run_core("rd_both");
    check_eq("rd_both_data", last_core_rd, 32'h5A5A_0F0F);

    // Simultaneous requests straight out of reset: management goes first
    do_reset();
    set_core(0, 1, 32'h010, 4'hF, 32'h0);
    w_pend = 1; w_we = 0; w_adr = 32'h010; w_sel = 4'hF; w_wd = '0;
    t0 = cyc;
    for (int i = 0; i < 12 && (c_pend || w_pend); i++) step();
    check_eq("contend_done", {30'd0, c_pend, w_pend}, 32'h0);
    check_eq("contend_wb_lat", 32'(wb_obs - t0), 32'(LAT));
    check_eq("contend_core_gap", 32'(core_obs - wb_obs), 32'(LAT + 1));
    check_eq("contend_wb_data", last_wb_rd, 32'h1234_AB78);
    check_eq("contend_core_data", last_core_rd, 32'h1234_AB78);

    // Reset while the access is in flight, request still held
    set_core(1, 0, 32'h014, 4'hF, 32'hCAFE_F00D);
    step();
    @(posedge clk);
    #2;
    do_reset();
    set_core(0, 1, 32'h014, 4'hF, 32'h0); run_core("post_rst_rd");
    check_eq("post_rst_data", last_core_rd, 32'hCAFE_F00D);

    for (int n = 0; n < 400; n++) begin
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        r = int'($urandom_range(0, 2));
        set_core(r != 0, r != 1, rand_addr(), 4'($urandom_range(0, 15)), $urandom());
      end
      if (!w_pend && $urandom_range(0, 2) != 0) begin
        w_pend = 1; w_we = 1'($urandom_range(0, 1)); w_adr = rand_addr();
        w_sel = 4'($urandom_range(0, 15)); w_wd = $urandom();
      end
      step();
    end
    for (int i = 0; i < 20 && (c_pend || w_pend); i++) step();
    check_eq("drain", {30'd0, c_pend, w_pend}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
